prog_host_driver: RTL and testbench
===================================

# prog_host_driver

Host-side driver for the nibble programming port of the CPU top level. It accepts one command frame (address, command, write data) over a valid/ready request interface and serializes it as 13 nibbles onto `prog_nibble_in`. It then collects any response nibbles from `prog_nibble_out` until `prog_done` arrives or a timeout expires, and returns one packed response per request. It sits directly upstream of the CPU programming interface and is its only driver.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: maximum WAIT-state cycles before the request is aborted (≥2).
- `NIBBLE_GAP`, 0: idle cycles with `prog_nibble_in_valid`=0 inserted after each transmitted nibble (0..15).

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request frame present
- `req_ready`  out  1  driver can accept a frame
- `req_addr`  in  12  frame address
- `req_cmd`  in  8  frame command byte
- `req_wdata`  in  32  frame write data
- `prog_nibble_in`  out  4  nibble to the CPU programming port
- `prog_nibble_in_valid`  out  1  nibble qualifier
- `prog_nibble_out`  in  4  response nibble from the CPU
- `prog_out_valid`  in  1  response nibble qualifier
- `prog_done`  in  1  command-complete pulse from the CPU
- `rsp_valid`  out  1  one-cycle response pulse
- `rsp_data`  out  32  collected response word
- `rsp_has_data`  out  1  exactly 8 response nibbles received
- `rsp_status`  out  2  00 OK, 01 malformed response, 10 timeout, 11 unused

## Operation
- FSM states are IDLE, SEND, WAIT, RESP. Reset enters IDLE.
- **IDLE:** `req_ready`=1, decoded combinationally from the state. On `req_valid && req_ready`:
  - latch the 52-bit frame {addr, cmd, wdata} into a shift register;
  - clear the nibble counter, response counter, `rsp_data` accumulator and timer;
  - go to SEND.
- **SEND:**
  - Drive `prog_nibble_in` = shift[51:48] with valid=1 for exactly one cycle, then shift left 4 bits.
  - Follow each nibble with `NIBBLE_GAP` idle cycles.
  - Transmission order is MSB first: addr[11:8], addr[7:4], addr[3:0], cmd[7:4], cmd[3:0], wdata[31:28] … wdata[3:0].
  - After the 13th nibble (and no trailing gap), go to WAIT.
- **WAIT:**
  - Each cycle with `prog_out_valid`=1: accumulator <= {acc[27:0], `prog_nibble_out`}. The response count increments and saturates at 15.
  - `prog_done`=1 goes to RESP. A nibble valid in the same cycle as `prog_done` is still captured.
  - The timer increments every WAIT cycle. When timer = `TIMEOUT_CYCLES`-1 without `prog_done`, go to RESP flagged as timeout.
- **RESP:** assert `rsp_valid` for one cycle, then return to IDLE.
  - Status when `prog_done` was seen:
    - count 0: status 00, `rsp_has_data`=0;
    - count 8: status 00, `rsp_has_data`=1;
    - any other count: status 01, `rsp_has_data`=0.
  - Status on timeout: 10, `rsp_has_data`=0, whatever the count.
  - `rsp_data` always shows the accumulator.
- `prog_out_valid` and `prog_done` are ignored in IDLE, SEND and RESP.
- `rsp_data`, `rsp_has_data` and `rsp_status` hold until the next RESP.

## Timing
- Reset values (applied immediately on `rst`, asynchronously):
  - state IDLE;
  - `req_ready`=1;
  - `prog_nibble_in`=0, `prog_nibble_in_valid`=0;
  - `rsp_valid`=0, `rsp_data`=0, `rsp_has_data`=0, `rsp_status`=00.
- Let the request handshake edge be cycle 0.
  - Nibble k (0..12) is valid in cycle 1 + k·(`NIBBLE_GAP`+1).
  - WAIT begins the cycle after nibble 12.
- `prog_done` sampled at edge T gives `rsp_valid` during cycle T+1, and `req_ready`=1 from cycle T+2.
- Timeout: `rsp_valid` occurs exactly `TIMEOUT_CYCLES` cycles after WAIT entry.
- `req_ready`=0 from cycle 1 until IDLE is re-entered. There is no back-to-back acceptance in RESP.
- Reset mid-SEND or mid-WAIT:
  - the frame is discarded;
  - no `rsp_valid` is produced;
  - valid drops within the reset assertion, with no glitch nibble afterwards.
- The request fields are sampled only at the handshake edge. Later changes are ignored.

## Test plan
- Write frame addr=0x123, cmd=0x01, wdata=0xDEADBEEF, GAP=0 → nibbles 1,2,3,0,1,D,E,A,D,B,E,E,F in cycles 1..13. Then `prog_done` with no data → `rsp_valid` with status 00, `rsp_has_data`=0.
- Read frame addr=0x0FF, cmd=0x02; CPU returns nibbles 1..8, then `prog_done` → `rsp_data`=0x12345678, `rsp_has_data`=1, status 00.
- `prog_done` coincident with the 8th response nibble → nibble captured, `rsp_data` complete, status 00.
- Only 5 response nibbles, then `prog_done` → status 01, `rsp_has_data`=0.
- `TIMEOUT_CYCLES`=16 with no `prog_done` → `rsp_valid` exactly 16 cycles after WAIT entry, status 10. `req_ready` returns 1 the following cycle.
- `NIBBLE_GAP`=2 with `rst` pulsed at nibble 5:
  - nibble spacing is 3 cycles before the reset;
  - valid drops immediately on reset, with no `rsp_valid`;
  - a fresh request afterwards completes normally.

Source files
------------

// File: rtl/prog_host_driver.sv
// Host-side driver for the CPU nibble programming port: serializes one 52-bit
// command frame as 13 nibbles, then collects response nibbles until done or timeout.
module prog_host_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned NIBBLE_GAP     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_addr,
  input  logic [7:0]  req_cmd,
  input  logic [31:0] req_wdata,
  output logic [3:0]  prog_nibble_in,
  output logic        prog_nibble_in_valid,
  input  logic [3:0]  prog_nibble_out,
  input  logic        prog_out_valid,
  input  logic        prog_done,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_has_data,
  output logic [1:0]  rsp_status
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    GapLast  = 4'(NIBBLE_GAP);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StResp} state_t;

  state_t          state;
  logic [47:0]     shift;
  logic [3:0]      nib_cnt;
  logic [3:0]      gap_cnt;
  logic [TW-1:0]   timer;
  logic [31:0]     acc;
  logic [3:0]      rsp_cnt;

  logic            emit;
  logic [31:0]     acc_next;
  logic [3:0]      cnt_next;

  assign req_ready = (state == StIdle);

  always_comb begin
    emit     = 1'b0;
    acc_next = acc;
    cnt_next = rsp_cnt;
    if (state == StSend) begin
      // nib_cnt counts nibbles already put on the port, the first one at handshake
      if (prog_nibble_in_valid) emit = (nib_cnt != 4'd13) && (NIBBLE_GAP == 0);
      else                      emit = (gap_cnt == GapLast);
    end
    if (prog_out_valid) begin
      acc_next = {acc[27:0], prog_nibble_out};
      if (rsp_cnt != 4'd15) cnt_next = rsp_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= StIdle;
      shift                <= '0;
      nib_cnt              <= '0;
      gap_cnt              <= '0;
      timer                <= '0;
      acc                  <= '0;
      rsp_cnt              <= '0;
      prog_nibble_in       <= '0;
      prog_nibble_in_valid <= 1'b0;
      rsp_valid            <= 1'b0;
      rsp_data             <= '0;
      rsp_has_data         <= 1'b0;
      rsp_status           <= 2'b00;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            state                <= StSend;
            prog_nibble_in       <= req_addr[11:8];
            prog_nibble_in_valid <= 1'b1;
            shift                <= {req_addr[7:0], req_cmd, req_wdata};
            nib_cnt              <= 4'd1;
            gap_cnt              <= '0;
            timer                <= '0;
            acc                  <= '0;
            rsp_cnt              <= '0;
          end
        end
        StSend: begin
          if (emit) begin
            prog_nibble_in       <= shift[47:44];
            prog_nibble_in_valid <= 1'b1;
            shift                <= {shift[43:0], 4'h0};
            nib_cnt              <= nib_cnt + 4'd1;
          end else if (prog_nibble_in_valid) begin
            prog_nibble_in_valid <= 1'b0;
            gap_cnt              <= 4'd1;
            if (nib_cnt == 4'd13) state <= StWait;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        StWait: begin
          acc     <= acc_next;
          rsp_cnt <= cnt_next;
          if (prog_done) begin
            state        <= StResp;
            rsp_valid    <= 1'b1;
            rsp_data     <= acc_next;
            rsp_has_data <= (cnt_next == 4'd8);
            rsp_status   <= ((cnt_next == 4'd0) || (cnt_next == 4'd8)) ? 2'b00 : 2'b01;
          end else if (timer == TimerMax) begin
            state        <= StResp;
            rsp_valid    <= 1'b1;
            rsp_data     <= acc_next;
            rsp_has_data <= 1'b0;
            rsp_status   <= 2'b10;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        StResp: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_host_driver.sv
// Directed bench for prog_host_driver: one instance with GAP=0/TIMEOUT=16, one with GAP=2.
module tb_prog_host_driver;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        req_valid, req_valid2;
  logic [11:0] req_addr;
  logic [7:0]  req_cmd;
  logic [31:0] req_wdata;
  logic [3:0]  prog_nibble_out;
  logic        prog_out_valid, prog_done;

  logic        req_ready, nib_valid, rsp_valid, rsp_has_data;
  logic [3:0]  nib;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;

  logic        req_ready2, nib_valid2, rsp_valid2, rsp_has_data2;
  logic [3:0]  nib2;
  logic [31:0] rsp_data2;
  logic [1:0]  rsp_status2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prog_host_driver #(.TIMEOUT_CYCLES(16), .NIBBLE_GAP(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_cmd(req_cmd), .req_wdata(req_wdata),
    .prog_nibble_in(nib), .prog_nibble_in_valid(nib_valid),
    .prog_nibble_out(prog_nibble_out), .prog_out_valid(prog_out_valid),
    .prog_done(prog_done), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_has_data(rsp_has_data), .rsp_status(rsp_status)
  );

  prog_host_driver #(.TIMEOUT_CYCLES(16), .NIBBLE_GAP(2)) dut2 (
    .clk(clk), .rst(rst2), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_addr(req_addr), .req_cmd(req_cmd), .req_wdata(req_wdata),
    .prog_nibble_in(nib2), .prog_nibble_in_valid(nib_valid2),
    .prog_nibble_out(prog_nibble_out), .prog_out_valid(prog_out_valid),
    .prog_done(prog_done), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .rsp_has_data(rsp_has_data2), .rsp_status(rsp_status2)
  );

  function automatic logic [3:0] frame_nib(input logic [51:0] f, input int k);
    return f[51-4*k -: 4];
  endfunction

  // Handshake a frame on the GAP=0 instance and check all 13 nibbles (cycles 1..13).
  task automatic send_frame(input logic [11:0] a, input logic [7:0] c, input logic [31:0] w);
    logic [51:0] f;
    f = {a, c, w};
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_cmd = c; req_wdata = w;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~a; req_cmd = ~c; req_wdata = ~w;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      total++;
      if (nib_valid !== 1'b1 || nib !== frame_nib(f, k) || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL nibble%0d: got v=%b n=%h rdy=%b want v=1 n=%h rdy=0",
                 k, nib_valid, nib, req_ready, frame_nib(f, k));
      end
    end
  endtask

  // CPU side: n response nibbles from d (MSB first), then prog_done (or on the last nibble).
  // Returns in the cycle after the done edge.
  task automatic cpu_reply(input int n, input logic [31:0] d, input bit coincide);
    for (int i = 0; i < n; i++) begin
      prog_out_valid  = 1'b1;
      prog_nibble_out = d[31-4*i -: 4];
      prog_done       = coincide && (i == n - 1);
      @(posedge clk); #1;
    end
    prog_out_valid = 1'b0; prog_nibble_out = 4'h0; prog_done = 1'b0;
    if (!coincide || n == 0) begin
      prog_done = 1'b1;
      @(posedge clk); #1;
      prog_done = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rst2 = 1'b1;
    req_valid = 1'b0; req_valid2 = 1'b0;
    req_addr = '0; req_cmd = '0; req_wdata = '0;
    prog_nibble_out = '0; prog_out_valid = 1'b0; prog_done = 1'b0;
    #2;
    total++;
    if (req_ready !== 1'b1 || nib_valid !== 1'b0 || nib !== 4'h0 || rsp_valid !== 1'b0 ||
        rsp_data !== 32'h0 || rsp_has_data !== 1'b0 || rsp_status !== 2'b00) begin
      bad++;
      $display("FAIL reset: got rdy=%b v=%b n=%h rv=%b d=%h hd=%b st=%b want 1 0 0 0 0 0 00",
               req_ready, nib_valid, nib, rsp_valid, rsp_data, rsp_has_data, rsp_status);
    end
    total++;
    if (req_ready2 !== 1'b1 || nib_valid2 !== 1'b0 || rsp_valid2 !== 1'b0) begin
      bad++;
      $display("FAIL reset2: got rdy=%b v=%b rv=%b want 1 0 0", req_ready2, nib_valid2, rsp_valid2);
    end
    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
  endtask

  task automatic test_write;
    send_frame(12'h123, 8'h01, 32'hDEADBEEF);
    @(posedge clk); #1;
    cpu_reply(0, 32'h0, 1'b0);
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_has_data !== 1'b0 ||
        rsp_data !== 32'h0 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL write_rsp: got rv=%b st=%b hd=%b d=%h rdy=%b want 1 00 0 0 0",
               rsp_valid, rsp_status, rsp_has_data, rsp_data, req_ready);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL write_after: got rv=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_read;
    send_frame(12'h0FF, 8'h02, 32'h0);
    @(posedge clk); #1;
    cpu_reply(8, 32'h12345678, 1'b0);
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h12345678 || rsp_has_data !== 1'b1 ||
        rsp_status !== 2'b00) begin
      bad++;
      $display("FAIL read_rsp: got rv=%b d=%h hd=%b st=%b want 1 12345678 1 00",
               rsp_valid, rsp_data, rsp_has_data, rsp_status);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 32'h12345678 ||
        rsp_has_data !== 1'b1) begin
      bad++;
      $display("FAIL read_hold: got rv=%b rdy=%b d=%h hd=%b want 0 1 12345678 1",
               rsp_valid, req_ready, rsp_data, rsp_has_data);
    end
  endtask

  task automatic test_done_coincident;
    send_frame(12'hA5A, 8'h03, 32'h55AA55AA);
    @(posedge clk); #1;
    cpu_reply(8, 32'hCAFEF00D, 1'b1);
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFEF00D || rsp_has_data !== 1'b1 ||
        rsp_status !== 2'b00) begin
      bad++;
      $display("FAIL coincident: got rv=%b d=%h hd=%b st=%b want 1 cafef00d 1 00",
               rsp_valid, rsp_data, rsp_has_data, rsp_status);
    end
  endtask

  task automatic test_malformed;
    @(negedge clk);
    send_frame(12'h000, 8'hFF, 32'h01234567);
    @(posedge clk); #1;
    cpu_reply(5, 32'h9ABCD000, 1'b0);
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0009ABCD || rsp_has_data !== 1'b0 ||
        rsp_status !== 2'b01) begin
      bad++;
      $display("FAIL malformed: got rv=%b d=%h hd=%b st=%b want 1 0009abcd 0 01",
               rsp_valid, rsp_data, rsp_has_data, rsp_status);
    end
  endtask

  task automatic test_timeout;
    int early;
    early = 0;
    @(negedge clk);
    send_frame(12'h456, 8'h04, 32'h00000000);
    // WAIT occupies cycles 14..29; response pulse expected in cycle 30
    for (int c = 14; c < 30; c++) begin
      @(posedge clk); #1;
      prog_out_valid  = (c == 14) || (c == 15);
      prog_nibble_out = (c == 14) ? 4'hA : (c == 15) ? 4'hB : 4'h0;
      @(negedge clk);
      if (rsp_valid !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL timeout_early: got %0d early pulses want 0", early);
    end
    @(posedge clk); #1;
    prog_out_valid = 1'b0;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_has_data !== 1'b0 ||
        rsp_data !== 32'h000000AB) begin
      bad++;
      $display("FAIL timeout_rsp: got rv=%b st=%b hd=%b d=%h want 1 10 0 000000ab",
               rsp_valid, rsp_status, rsp_has_data, rsp_data);
    end
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL timeout_ready: got rdy=%b rv=%b want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_gap_reset;
    logic [51:0] f;
    int          errs;
    bit          ev;
    f = {12'h789, 8'h5C, 32'h13579BDF};
    errs = 0;
    @(posedge clk); #1;
    req_valid2 = 1'b1; req_addr = f[51:40]; req_cmd = f[39:32]; req_wdata = f[31:0];
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      ev = ((c - 1) % 3) == 0;
      if (nib_valid2 !== ev || (ev && nib2 !== frame_nib(f, (c - 1) / 3))) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL gap_spacing: got %0d bad cycles want 0", errs);
    end
    @(posedge clk); #1;
    total++;
    if (nib_valid2 !== 1'b1 || nib2 !== frame_nib(f, 5)) begin
      bad++;
      $display("FAIL gap_nib5: got v=%b n=%h want 1 %h", nib_valid2, nib2, frame_nib(f, 5));
    end
    rst2 = 1'b1;
    #1;
    total++;
    if (nib_valid2 !== 1'b0 || nib2 !== 4'h0 || req_ready2 !== 1'b1) begin
      bad++;
      $display("FAIL gap_rst: got v=%b n=%h rdy=%b want 0 0 1", nib_valid2, nib2, req_ready2);
    end
    @(negedge clk);
    rst2 = 1'b0;
    errs = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (nib_valid2 !== 1'b0 || rsp_valid2 !== 1'b0 || req_ready2 !== 1'b1) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL gap_quiet: got %0d bad cycles want 0", errs);
    end
    f = {12'h0F0, 8'h0E, 32'hFEDCBA98};
    errs = 0;
    @(posedge clk); #1;
    req_valid2 = 1'b1; req_addr = f[51:40]; req_cmd = f[39:32]; req_wdata = f[31:0];
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      ev = ((c - 1) % 3) == 0;
      if (nib_valid2 !== ev || (ev && nib2 !== frame_nib(f, (c - 1) / 3))) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL gap_frame2: got %0d bad cycles want 0", errs);
    end
    @(posedge clk); #1;
    cpu_reply(8, 32'h87654321, 1'b0);
    @(negedge clk);
    total++;
    if (rsp_valid2 !== 1'b1 || rsp_data2 !== 32'h87654321 || rsp_has_data2 !== 1'b1 ||
        rsp_status2 !== 2'b00) begin
      bad++;
      $display("FAIL gap_rsp: got rv=%b d=%h hd=%b st=%b want 1 87654321 1 00",
               rsp_valid2, rsp_data2, rsp_has_data2, rsp_status2);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_done_coincident();
    test_malformed();
    test_timeout();
    test_gap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
